interrupt_matrix_ctrl: RTL and testbench
========================================

Name: interrupt_matrix_ctrl

Overview:
Parametrised interrupt router for the PWM carrier/counter blocks. It captures N_SRC interrupt sources into sticky pending flags, with per-source level or rising-edge detection. Pending flags are routed through a per-output enable matrix to N_OUT registered interrupt lines. It also provides a one-cycle pulse per output and a saturating per-output event counter. It sits between the PWM event generators and the AXI4-Lite register file, which drives the mode, matrix and clear inputs.

Parameters:
N_SRC, 8, number of interrupt sources (1..32)
N_OUT, 2, number of routed interrupt outputs (1..8)
CNT_W, 16, width of each per-output event counter

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
src_in  in  N_SRC  raw interrupt sources, already synchronous to clk
mode  in  N_SRC  per-source detect mode: 0 = level, 1 = rising edge
matrix  in  N_OUT*N_SRC  enable matrix; bit [o*N_SRC+s] routes source s to output o
clr_valid  in  1  clear strobe, one cycle
clr_mask  in  N_SRC  write-1-to-clear mask, qualified by clr_valid
cnt_clr  in  N_OUT  per-output counter clear
pending  out  N_SRC  sticky pending flags
irq_out  out  N_OUT  registered level interrupt per output
irq_pulse  out  N_OUT  one-cycle pulse on each rising edge of irq_out
irq_cnt  out  N_OUT*CNT_W  per-output rising-edge count; field o at [o*CNT_W +: CNT_W]

Behaviour:
- Reset (rst=1 at clk edge): src_q, pending, irq_out, irq_pulse and all irq_cnt fields go to 0. Reset overrides every other input, including a clear or set in the same cycle.
- src_q: register of src_in, updated every cycle.
- Set condition per source s:
  - mode[s]=1: set_s = src_in[s] & ~src_q[s] (rising edge)
  - mode[s]=0: set_s = src_in[s]
- Clear condition per source s: clr_s = clr_valid & clr_mask[s].
- pending[s] next value = set_s | (pending[s] & ~clr_s).
  - Set wins over a simultaneous clear.
  - In level mode, a cleared flag re-asserts the next cycle while src_in stays high.
- Latency:
  - src_in rises at edge t → pending visible after edge t+1.
  - irq_out[o] = |(pending & matrix row o), registered, so visible after edge t+2.
- A matrix change takes effect on irq_out one cycle later.
  - Masking a pending source drops irq_out; pending itself is unaffected.
- Mode change: a pending flag is kept. The edge detector uses the existing src_q, so switching level→edge while the source is high does not generate a new edge.
- irq_pulse[o] = irq_out_next[o] & ~irq_out[o], registered alongside irq_out, so it is high in the same cycle irq_out first goes high.
- irq_cnt[o]:
  - Increments by 1 on each irq_pulse[o] (same edge that asserts irq_pulse).
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr[o] forces 0 and takes priority over a simultaneous increment.
- An edge-mode source held high produces exactly one set, and after a clear it stays cleared until the source falls and rises again.
- No combinational path from any input to any output.

Test Plan:
- Reset, all inputs 0 → pending=0, irq_out=0, irq_cnt=0; hold rst=1 while src_in=8'hFF → all outputs stay 0.
- Edge mode: mode=8'hFF, matrix row0=8'h01, src_in[0] 0→1 and held 10 cycles → pending=8'h01 after 1 cycle, irq_out[0]=1 after 2 cycles, irq_pulse[0] for exactly 1 cycle, irq_cnt0=1; clr_mask=8'h01 pulse → pending=0, irq_out[0]=0 two cycles after the clear edge.
- Level mode: mode=0, src_in[3]=1 held, clear bit 3 → pending[3] drops for 0 cycles visible (re-set wins), stays 1; release src_in then clear → pending[3]=0.
- Simultaneous: in edge mode, src_in[2] rising edge in the same cycle as clr_mask[2] → pending[2]=1.
- Routing: pending=8'h30, matrix row0=8'h10, row1=8'h0F → irq_out=2'b01; change row1 to 8'h20 → irq_out=2'b11 one cycle later, irq_cnt1 increments once.
- Counter: CNT_W=4, 20 isolated edges on source 0 routed to output 0 → irq_cnt0 saturates at 15; cnt_clr[0] asserted in the same cycle as a pulse → irq_cnt0=0.

Source files
------------

// File: rtl/interrupt_matrix_ctrl.sv
// Interrupt router: sticky pending flags with level/edge capture, per-output enable
// matrix, registered interrupt lines, one-cycle pulses and saturating event counters.
module interrupt_matrix_ctrl #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         src_in,
  input  logic [N_SRC-1:0]         mode,
  input  logic [N_OUT*N_SRC-1:0]   matrix,
  input  logic                     clr_valid,
  input  logic [N_SRC-1:0]         clr_mask,
  input  logic [N_OUT-1:0]         cnt_clr,
  output logic [N_SRC-1:0]         pending,
  output logic [N_OUT-1:0]         irq_out,
  output logic [N_OUT-1:0]         irq_pulse,
  output logic [N_OUT*CNT_W-1:0]   irq_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [N_SRC-1:0]       src_q, src_d;
  logic [N_SRC-1:0]       pending_q, pending_d;
  logic [N_OUT-1:0]       irq_out_q, irq_out_d;
  logic [N_OUT-1:0]       irq_pulse_q, irq_pulse_d;
  logic [N_OUT*CNT_W-1:0] cnt_q, cnt_d;

  logic [N_SRC-1:0] set_s;
  logic [N_SRC-1:0] clr_s;

  always_comb begin
    src_d = src_in;
    // Edge mode suppresses a set while the previous sample was already high.
    set_s = src_in & ~(mode & src_q);
    clr_s = {N_SRC{clr_valid}} & clr_mask;
    pending_d = set_s | (pending_q & ~clr_s);
  end

  always_comb begin
    irq_out_d   = '0;
    irq_pulse_d = '0;
    cnt_d       = cnt_q;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      irq_out_d[o]   = |(pending_q & matrix[o*N_SRC +: N_SRC]);
      irq_pulse_d[o] = irq_out_d[o] & ~irq_out_q[o];
      if (cnt_clr[o]) begin
        cnt_d[o*CNT_W +: CNT_W] = '0;
      end else if (irq_pulse_d[o] && (cnt_q[o*CNT_W +: CNT_W] != CntMax)) begin
        cnt_d[o*CNT_W +: CNT_W] = cnt_q[o*CNT_W +: CNT_W] + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q       <= '0;
      pending_q   <= '0;
      irq_out_q   <= '0;
      irq_pulse_q <= '0;
      cnt_q       <= '0;
    end else begin
      src_q       <= src_d;
      pending_q   <= pending_d;
      irq_out_q   <= irq_out_d;
      irq_pulse_q <= irq_pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pending   = pending_q;
  assign irq_out   = irq_out_q;
  assign irq_pulse = irq_pulse_q;
  assign irq_cnt   = cnt_q;

endmodule

// File: tb/tb_interrupt_matrix_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle model.
module tb_interrupt_matrix_ctrl;

  localparam int NS = 8;
  localparam int NO = 2;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NS-1:0]  src_in = '0;
  logic [NS-1:0]  mode = '0;
  logic [NO*NS-1:0] matrix = '0;
  logic           clr_valid = 1'b0;
  logic [NS-1:0]  clr_mask = '0;
  logic [NO-1:0]  cnt_clr = '0;
  logic [NS-1:0]  pending;
  logic [NO-1:0]  irq_out;
  logic [NO-1:0]  irq_pulse;
  logic [NO*CW-1:0] irq_cnt;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_matrix_ctrl #(.N_SRC(NS), .N_OUT(NO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .mode      (mode),
    .matrix    (matrix),
    .clr_valid (clr_valid),
    .clr_mask  (clr_mask),
    .cnt_clr   (cnt_clr),
    .pending   (pending),
    .irq_out   (irq_out),
    .irq_pulse (irq_pulse),
    .irq_cnt   (irq_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: per-source and per-output bits, counters as plain integers.
  bit m_src  [NS];
  bit m_pend [NS];
  bit m_irq  [NO];
  bit m_pulse[NO];
  int m_cnt  [NO];

  always @(posedge clk) begin : model_p
    bit np[NS];
    bit ni[NO];
    bit nq[NO];
    bit lvl;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin m_src[s] = 0; m_pend[s] = 0; end
      for (int o = 0; o < NO; o++) begin m_irq[o] = 0; m_pulse[o] = 0; m_cnt[o] = 0; end
    end else begin
      for (int s = 0; s < NS; s++) begin
        bit set_now, clr_now;
        set_now = mode[s] ? (src_in[s] && !m_src[s]) : src_in[s];
        clr_now = clr_valid && clr_mask[s];
        np[s] = set_now ? 1'b1 : (clr_now ? 1'b0 : m_pend[s]);
      end
      for (int o = 0; o < NO; o++) begin
        lvl = 0;
        for (int s = 0; s < NS; s++) if (m_pend[s] && matrix[o*NS+s]) lvl = 1;
        ni[o] = lvl;
        nq[o] = lvl && !m_irq[o];
        if (cnt_clr[o]) m_cnt[o] = 0;
        else if (nq[o] && m_cnt[o] < CMAX) m_cnt[o] = m_cnt[o] + 1;
      end
      for (int s = 0; s < NS; s++) begin m_src[s] = src_in[s]; m_pend[s] = np[s]; end
      for (int o = 0; o < NO; o++) begin m_irq[o] = ni[o]; m_pulse[o] = nq[o]; end
    end
    #1;
    begin
      logic [NS-1:0] ep;
      logic [NO-1:0] ei, eq;
      for (int s = 0; s < NS; s++) ep[s] = m_pend[s];
      for (int o = 0; o < NO; o++) begin ei[o] = m_irq[o]; eq[o] = m_pulse[o]; end
      chk("model_pending", 32'(pending), 32'(ep));
      chk("model_irq_out", 32'(irq_out), 32'(ei));
      chk("model_irq_pulse", 32'(irq_pulse), 32'(eq));
      for (int o = 0; o < NO; o++)
        chk("model_irq_cnt", 32'(irq_cnt[o*CW +: CW]), 32'(m_cnt[o]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset holds everything at zero even with all sources high.
    src_in = 8'hFF;
    tick(3);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_irq_out", 32'(irq_out), 32'h0);
    chk("rst_irq_cnt", 32'(irq_cnt), 32'h0);
    src_in = '0;
    rst = 1'b0;
    tick(2);

    // Edge mode on source 0 routed to output 0.
    mode = 8'hFF;
    matrix = 16'h0001;
    src_in = 8'h01;
    tick(1);
    chk("edge_pending", 32'(pending), 32'h01);
    chk("edge_irq_early", 32'(irq_out), 32'h0);
    tick(1);
    chk("edge_irq_out", 32'(irq_out), 32'h1);
    chk("edge_pulse", 32'(irq_pulse), 32'h1);
    chk("edge_cnt0", 32'(irq_cnt[CW-1:0]), 32'h1);
    tick(1);
    chk("edge_pulse_end", 32'(irq_pulse), 32'h0);
    tick(6);
    clr_valid = 1'b1;
    clr_mask = 8'h01;
    tick(1);
    clr_valid = 1'b0;
    clr_mask = '0;
    chk("edge_clr_pending", 32'(pending), 32'h0);
    chk("edge_clr_irq_lag", 32'(irq_out), 32'h1);
    tick(1);
    chk("edge_clr_irq", 32'(irq_out), 32'h0);

    // Level mode: clearing while the source is high does not stick.
    mode = '0;
    src_in = 8'h08;
    tick(2);
    clr_valid = 1'b1;
    clr_mask = 8'h08;
    tick(1);
    clr_valid = 1'b0;
    chk("level_reset_wins", 32'(pending[3]), 32'h1);
    src_in = '0;
    tick(1);
    clr_valid = 1'b1;
    tick(1);
    clr_valid = 1'b0;
    chk("level_released", 32'(pending[3]), 32'h0);

    // Set beats a simultaneous clear.
    mode = 8'hFF;
    tick(1);
    src_in = 8'h04;
    clr_valid = 1'b1;
    clr_mask = 8'h04;
    tick(1);
    clr_valid = 1'b0;
    chk("simul_set_wins", 32'(pending[2]), 32'h1);
    clr_valid = 1'b1;
    clr_mask = 8'hFF;
    tick(1);
    clr_valid = 1'b0;
    src_in = '0;
    tick(2);

    // Routing and a matrix update.
    src_in = 8'h30;
    matrix = {8'h0F, 8'h10};
    tick(2);
    chk("route_pending", 32'(pending), 32'h30);
    chk("route_irq", 32'(irq_out), 32'h1);
    chk("route_cnt1_before", 32'(irq_cnt[2*CW-1:CW]), 32'h0);
    matrix = {8'h20, 8'h10};
    tick(1);
    chk("route_irq_both", 32'(irq_out), 32'h3);
    chk("route_cnt1_after", 32'(irq_cnt[2*CW-1:CW]), 32'h1);
    clr_valid = 1'b1;
    clr_mask = 8'hFF;
    src_in = '0;
    tick(1);
    clr_valid = 1'b0;
    tick(2);

    // Counter saturation with twenty isolated edges.
    mode = 8'h01;
    matrix = 16'h0001;
    for (int i = 0; i < 20; i++) begin
      src_in = 8'h01;
      tick(1);
      src_in = '0;
      clr_valid = 1'b1;
      clr_mask = 8'h01;
      tick(1);
      clr_valid = 1'b0;
      tick(2);
    end
    chk("cnt_saturate", 32'(irq_cnt[CW-1:0]), 32'(CMAX));
    src_in = 8'h01;
    tick(1);
    cnt_clr = 2'b01;
    tick(1);
    cnt_clr = '0;
    chk("cnt_clr_pulse", 32'(irq_pulse[0]), 32'h1);
    chk("cnt_clr_wins", 32'(irq_cnt[CW-1:0]), 32'h0);
    src_in = '0;
    tick(2);

    // Randomized traffic; the model compares every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) src_in = NS'($urandom);
      if ($urandom_range(0, 15) == 0) mode = NS'($urandom);
      if ($urandom_range(0, 15) == 0) matrix = (NO*NS)'($urandom);
      clr_valid = ($urandom_range(0, 3) == 0);
      clr_mask = NS'($urandom);
      cnt_clr = ($urandom_range(0, 31) == 0) ? NO'($urandom) : '0;
      tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
